// File: rtl/regfile8.sv
// Eight-entry register file: one synchronous write port, two combinational read ports, r7 hardwired to zero.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile8 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic [2:0]       write_register,
    input  logic [WIDTH-1:0] write_data,
    input  logic [2:0]       read_register1,
    input  logic [2:0]       read_register2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);

    // Only r0..r6 have storage, so the decode stops at index 6; a write to r7 enables nothing.
    logic [6:0]       we;
    logic [WIDTH-1:0] regs [7];
    logic [WIDTH-1:0] view [8];

    always_comb begin
        we = '0;
        for (int k = 0; k < 7; k++) begin
            we[k] = reg_write && (write_register == 3'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 7; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (we[k]) begin
                    regs[k] <= write_data;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            view[k] = regs[k];
        end
        view[7] = '0;
    end

`ifdef REGFILE_BYPASS_EN
    // Forward only to a real register and never during reset, when the pending write is discarded.
    logic fwd1;
    logic fwd2;

    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
        if (!reset && read_register1 != 3'd7) begin
            fwd1 = we[read_register1];
        end
        if (!reset && read_register2 != 3'd7) begin
            fwd2 = we[read_register2];
        end
    end

    assign read_data1 = fwd1 ? write_data : view[read_register1];
    assign read_data2 = fwd2 ? write_data : view[read_register2];
`else
    assign read_data1 = view[read_register1];
    assign read_data2 = view[read_register2];
`endif

endmodule

// File: tb/tb_regfile8.sv
// Randomized scoreboard bench for regfile8: the driver predicts both read ports from an array model,
// a negedge monitor pops the prediction and compares against the DUT outputs.
module tb_regfile8;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         reg_write;
    logic [2:0]   write_register;
    logic [W-1:0] write_data;
    logic [2:0]   read_register1;
    logic [2:0]   read_register2;
    logic [W-1:0] read_data1;
    logic [W-1:0] read_data2;

    regfile8 #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .read_register1 (read_register1),
        .read_register2 (read_register2),
        .read_data1     (read_data1),
        .read_data2     (read_data2)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // reference model: architectural contents of r0..r7 (r7 always zero)
    logic [W-1:0]   model [8];
    logic [2*W-1:0] exp_q [$];
    string          tag_q [$];
    int             vectors = 0;
    int             miscompares = 0;

    function automatic logic [W-1:0] predict(input logic [2:0] idx, input logic rst, input logic wen,
                                             input logic [2:0] wr, input logic [W-1:0] wd);
        if (idx == 3'd7) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && wen && wr == idx) return wd;
`endif
        return model[idx];
    endfunction

    // driver: drive after the posedge, predict, then retire the write into the model at the next edge
    task automatic apply(input logic rst, input logic wen, input logic [2:0] wr, input logic [W-1:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2, input bit chk, input string tag);
        reset          = rst;
        reg_write      = wen;
        write_register = wr;
        write_data     = wd;
        read_register1 = r1;
        read_register2 = r2;
        if (chk) begin
            exp_q.push_back({predict(r1, rst, wen, wr, wd), predict(r2, rst, wen, wr, wd)});
            tag_q.push_back(tag);
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 8; k++) model[k] = '0;
        end else if (wen && wr != 3'd7) begin
            model[wr] = wd;
        end
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2*W-1:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            if ({read_data1, read_data2} !== e) begin
                miscompares++;
                $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h", t, read_data1, read_data2,
                         e[2*W-1:W], e[W-1:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_register = '0; write_data = '0;
        read_register1 = '0; read_register2 = '0;
        @(posedge clk); #1;

        // reset held two cycles with a pending write to r3
        apply(1, 1, 3'd3, 64'hDEAD, 3'd3, 3'd3, 0, "reset_hold");
        apply(1, 1, 3'd3, 64'hDEAD, 3'd3, 3'd3, 0, "reset_hold");
        for (int i = 0; i < 8; i++) apply(0, 0, 3'd0, '0, 3'(i), 3'(7 - i), 1, "reset_zero");

        // basic writes r_k = k*0x1111, reading the target in the same cycle
        for (int k = 0; k < 7; k++) apply(0, 1, 3'(k), W'(k) * 64'h1111, 3'(k), 3'(6 - k), 1, "write_seq");
        for (int i = 0; i < 8; i++) apply(0, 0, 3'd0, '0, 3'(i), 3'(7 - i), 1, "read_sweep");

        // zero register ignores writes
        apply(0, 1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 3'd6, 1, "r7_write");
        for (int i = 0; i < 8; i++) apply(0, 0, 3'd0, '0, 3'd7, 3'(i), 1, "r7_after");

        // gated enable
        apply(0, 0, 3'd2, 64'h1234, 3'd2, 3'd2, 1, "gated");
        apply(0, 0, 3'd0, '0, 3'd2, 3'd2, 1, "gated_after");

        // same-cycle hazard on r5
        apply(0, 1, 3'd5, 64'hABCD, 3'd5, 3'd4, 1, "hazard");
        apply(0, 0, 3'd0, '0, 3'd5, 3'd5, 1, "hazard_after");

        // reset wins over a same-cycle write
        apply(1, 1, 3'd1, 64'h77, 3'd1, 3'd1, 1, "reset_wins");
        for (int i = 0; i < 8; i++) apply(0, 0, 3'd0, '0, 3'(i), 3'd1, 1, "reset_wins_after");

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1, "random");
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile8.md
# regfile8

Eight-entry, WIDTH-bit register file with one synchronous write port and two combinational read ports. The write path decodes a 3-bit register index into one-hot per-register write enables, gated by a global write enable. Decoded outputs are active only when the write enable is high. Entry 7 is hardwired to zero. The block is the storage stage that consumes the 3:8 enabled decode and feeds operands to the datapath.

## Interface
Parameters:
- WIDTH, 64, bit width of each register and data port.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all registers.
- reg_write  input  1  global write enable; gates the decoded per-register enables.
- write_register  input  3  index of the register written at the next rising edge.
- write_data  input  WIDTH  data written when reg_write=1.
- read_register1  input  3  index for read port 1.
- read_register2  input  3  index for read port 2.
- read_data1  output  WIDTH  contents of register read_register1.
- read_data2  output  WIDTH  contents of register read_register2.

## Operation
- Storage: registers r0..r6, each WIDTH bits, built from flip-flops. r7 has no storage; it reads as 0.
- Write decode: the block computes we[k] = reg_write & (write_register == k) for k = 0..7. At most one we[k] is high in any cycle. we[7] has no effect.
- Write: on a rising clk with reset=0 and we[k]=1 for k<7, rk <= write_data. All other registers hold their value.
- Read: read_dataN is a combinational 8:1 mux over {r0..r6, 0}, selected by read_registerN. Both ports are independent. Both ports may select the same register.
- Reset: on a rising clk with reset=1, r0..r6 <= 0. Reset has priority over any write in the same cycle.
- Reset mid-operation: when reset is asserted while reg_write=1, the write is discarded. Writes resume on the first edge at which reset=0.
- No arithmetic is performed. Data passes through unmodified at full WIDTH. There is no sign extension or truncation.

## Timing
- Write latency: 1 cycle. Data presented at edge n is visible on a read port after edge n, in the same cycle that follows (subject to Configuration).
- Read latency: 0 cycles, purely combinational from read_registerN and the stored state.
- Reset values: all stored registers are 0. read_data1 and read_data2 are therefore 0 after the reset edge, for every index.
- Same-cycle read/write of one index:
  - Without bypass, the read returns the old value until the edge.
  - With bypass, see Configuration.
- r7: reads 0 at every cycle, regardless of writes or bypass.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When reg_write=1, reset=0, write_register=k with k<7, and read_registerN=k, read_dataN = write_data combinationally in that same cycle. This is write-through forwarding.
  - Bypass never applies to r7.
  - Bypass never applies while reset=1; in that case the read returns the stored value.
- Undefined:
  - No forwarding. read_dataN always reflects the registered contents, so the old value is read until the write edge.

## Test plan
- Reset: hold reset=1 for 2 cycles with reg_write=1, write_register=3, write_data=64'hDEAD. Required: after release, both ports read 0 for every index 0..7.
- Basic write/read: write r_k = k*64'h1111 for k=0..6, one per cycle. Then sweep read_register1=0..7 and read_register2=7..0. Required: ports return k*64'h1111, and 0 for index 7.
- Zero register: write write_register=7 with write_data=64'hFFFF_FFFF_FFFF_FFFF. Required: read_data1 at index 7 is 0 in that cycle and in all following cycles; r0..r6 are unchanged.
- Gated enable: set reg_write=0, write_register=2, write_data=64'h1234. Required: r2 keeps its prior value (64'h2222 from the previous test).
- Same-cycle hazard: r5=64'h5555, then reg_write=1, write_register=5, write_data=64'hABCD, read_register1=5. Required: read_data1 is 64'hABCD in that cycle with REGFILE_BYPASS_EN defined, and 64'h5555 without it. In both builds it is 64'hABCD after the edge.
- Reset wins: reset=1, reg_write=1, write_register=1, write_data=64'h77. Required: r1 is 0 after the edge. With bypass defined, read_data at index 1 during the reset cycle shows the stored value, not 64'h77.
